// File: rtl/divisao_pkg.sv
// Shared definitions for the normalizer and the Goldschmidt divider (dividir).
// Q8.12 operand format, fixed-point constants and the sequencing state encoding.
package divisao_pkg;
    localparam int LARGURA = 20;
    localparam int FRAC    = 12;

    localparam logic [LARGURA-1:0] UM   = 20'h01000;
    localparam logic [LARGURA-1:0] DOIS = 20'h02000;
    localparam logic [LARGURA-1:0] MEIO = 20'h00800;
    localparam logic [LARGURA-1:0] SAT  = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } estado_t;
endpackage

// File: rtl/normalizar_divisao.sv
// Shifts a Q8.12 dividend/divisor pair until the divisor is in [0.5, 1.0) and emits F0 = 2 - divisor.
// Build option: define NORM_DUPLA_EN to shift two bits per cycle when at least two remain.
module normalizar_divisao
    import divisao_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LARGURA-1:0] dividendo_i,
    input  logic [LARGURA-1:0] divisor_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LARGURA-1:0] apDividendo_o,
    output logic [LARGURA-1:0] apDivisor_o,
    output logic [LARGURA-1:0] fator_o,
    output logic [4:0]         desloc_o,
    output logic               saturado_o,
    output logic               erro_div_zero_o
);
    estado_t             estado_q, estado_d;
    logic [LARGURA-1:0]  dvd_q, dvd_d, dvs_q, dvs_d;
    logic signed [4:0]   cnt_q, cnt_d;
    logic                sat_q, sat_d;

    logic [LARGURA-1:0]  ap_dvd_q, ap_dvd_d, ap_dvs_q, ap_dvs_d, fator_q, fator_d;
    logic [4:0]          desloc_q, desloc_d;
    logic                sat_o_q, sat_o_d, erro_q, erro_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= IDLE;
            dvd_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            ap_dvd_q <= '0;
            ap_dvs_q <= '0;
            fator_q  <= '0;
            desloc_q <= '0;
            sat_o_q  <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            ap_dvd_q <= ap_dvd_d;
            ap_dvs_q <= ap_dvs_d;
            fator_q  <= fator_d;
            desloc_q <= desloc_d;
            sat_o_q  <= sat_o_d;
            erro_q   <= erro_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        ap_dvd_d = ap_dvd_q;
        ap_dvs_d = ap_dvs_q;
        fator_d  = fator_q;
        desloc_d = desloc_q;
        sat_o_d  = sat_o_q;
        erro_d   = erro_q;

        case (estado_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d = dividendo_i;
                    dvs_d = divisor_i;
                    cnt_d = '0;
                    sat_d = 1'b0;
                    if (divisor_i == '0) begin
                        ap_dvd_d = '0;
                        ap_dvs_d = '0;
                        fator_d  = '0;
                        desloc_d = '0;
                        sat_o_d  = 1'b0;
                        erro_d   = 1'b1;
                        estado_d = DONE;
                    end else begin
                        estado_d = NORM;
                    end
                end
            end
            NORM: begin
                if (dvs_q[19:12] != '0) begin
`ifdef NORM_DUPLA_EN
                    if (dvs_q[19:13] != '0) begin
                        dvs_d = dvs_q >> 2;
                        dvd_d = dvd_q >> 2;
                        cnt_d = cnt_q - 5'sd2;
                    end else begin
                        dvs_d = dvs_q >> 1;
                        dvd_d = dvd_q >> 1;
                        cnt_d = cnt_q - 5'sd1;
                    end
`else
                    dvs_d = dvs_q >> 1;
                    dvd_d = dvd_q >> 1;
                    cnt_d = cnt_q - 5'sd1;
`endif
                end else if (!dvs_q[11]) begin
`ifdef NORM_DUPLA_EN
                    if (dvs_q[11:10] == 2'b00) begin
                        dvs_d = dvs_q << 2;
                        sat_d = sat_q | (dvd_q[19:18] != 2'b00);
                        dvd_d = sat_d ? SAT : (dvd_q << 2);
                        cnt_d = cnt_q + 5'sd2;
                    end else begin
                        dvs_d = dvs_q << 1;
                        sat_d = sat_q | dvd_q[19];
                        dvd_d = sat_d ? SAT : (dvd_q << 1);
                        cnt_d = cnt_q + 5'sd1;
                    end
`else
                    // Once saturated the dividend is pinned at SAT for the rest of the operation.
                    dvs_d = dvs_q << 1;
                    sat_d = sat_q | dvd_q[19];
                    dvd_d = sat_d ? SAT : (dvd_q << 1);
                    cnt_d = cnt_q + 5'sd1;
`endif
                end else begin
                    ap_dvd_d = dvd_q;
                    ap_dvs_d = dvs_q;
                    fator_d  = DOIS - dvs_q;
                    desloc_d = cnt_q;
                    sat_o_d  = sat_q;
                    erro_d   = 1'b0;
                    estado_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) estado_d = IDLE;
            end
            default: estado_d = IDLE;
        endcase
    end

    assign in_ready        = (estado_q == IDLE);
    assign out_valid       = (estado_q == DONE);
    assign apDividendo_o   = ap_dvd_q;
    assign apDivisor_o     = ap_dvs_q;
    assign fator_o         = fator_q;
    assign desloc_o        = desloc_q;
    assign saturado_o      = sat_o_q;
    assign erro_div_zero_o = erro_q;
endmodule
